// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, address-source codes
// and the default memory address width.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 5;

  localparam logic [1:0] ADDR_SRC_IDLE  = 2'b00;
  localparam logic [1:0] ADDR_SRC_FETCH = 2'b01;
  localparam logic [1:0] ADDR_SRC_DATA  = 2'b10;
  localparam logic [1:0] ADDR_SRC_SKIP  = 2'b11;

  // State codes equal the addr_src codes, so the source output is the state itself.
  typedef enum logic [1:0] {
    ST_IDLE  = ADDR_SRC_IDLE,
    ST_FETCH = ADDR_SRC_FETCH,
    ST_DATA  = ADDR_SRC_DATA,
    ST_SKIP  = ADDR_SRC_SKIP
  } seq_state_e;

  function automatic logic [1:0] state_to_src(input seq_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/mem_addr_sequencer_skip_latch.sv
// Pending skip holder: remembers the latest redirect target until the SKIP
// transaction that serves it has completed on the memory bus.
module mem_addr_sequencer_skip_latch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              take,
  input  logic              done,
  output logic              queued_eff,
  output logic [ADDR_W-1:0] target_eff,
  output logic              pending
);

  logic              queued_q;
  logic [ADDR_W-1:0] target_q;
  logic              pending_q;
  logic              queued_next;

  // A same-cycle request is visible to the current decision.
  assign queued_eff  = queued_q | set;
  assign target_eff  = set ? set_addr : target_q;
  assign queued_next = queued_eff & ~take;
  assign pending     = pending_q;

  // Pending stays high while a skip waits to launch or is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queued_q  <= 1'b0;
      target_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (set) begin
        target_q <= set_addr;
      end
      queued_q  <= queued_next;
      pending_q <= queued_next | take | (pending_q & ~done);
    end
  end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Registered memory address sequencer: arbitrates fetch, data and skip
// redirects onto one address bus and holds each address until mem_ready.
module mem_addr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter bit SKIP_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_active,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              skip_req,
  input  logic [ADDR_W-1:0] skip_addr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] address,
  output logic              addr_valid,
  output logic [1:0]        addr_src,
  output logic              data_ack,
  output logic              skip_ack,
  output logic              skip_pending
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              data_ack_q, skip_ack_q;
  logic              complete, decide;
  logic              data_done, skip_done, take_skip;
  logic              skip_queued;
  logic [ADDR_W-1:0] skip_target;

  mem_addr_sequencer_skip_latch #(
    .ADDR_W(ADDR_W)
  ) u_skip_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .set        (skip_req),
    .set_addr   (skip_addr),
    .take       (take_skip),
    .done       (skip_done),
    .queued_eff (skip_queued),
    .target_eff (skip_target),
    .pending    (skip_pending)
  );

  // Decision happens in IDLE or when the live transaction is accepted;
  // everything below is gated off while pc_active is low.
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    complete  = 1'b0;
    decide    = 1'b0;
    take_skip = 1'b0;
    data_done = 1'b0;
    skip_done = 1'b0;
    if (pc_active) begin
      complete  = (state_q != ST_IDLE) && mem_ready;
      decide    = (state_q == ST_IDLE) || mem_ready;
      data_done = complete && (state_q == ST_DATA);
      skip_done = complete && (state_q == ST_SKIP);
      if (decide) begin
        if (SKIP_PRIO && skip_queued) begin
          state_d   = ST_SKIP;
          address_d = skip_target;
          take_skip = 1'b1;
        end else if (data_req) begin
          state_d   = ST_DATA;
          address_d = data_addr;
        end else if (skip_queued) begin
          state_d   = ST_SKIP;
          address_d = skip_target;
          take_skip = 1'b1;
        end else begin
          state_d   = ST_FETCH;
          address_d = inst_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      address_q  <= '0;
      data_ack_q <= 1'b0;
      skip_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      data_ack_q <= data_done;
      skip_ack_q <= skip_done;
    end
  end

  assign address    = address_q;
  assign addr_src   = state_to_src(state_q);
  assign addr_valid = (state_q != ST_IDLE);
  assign data_ack   = data_ack_q;
  assign skip_ack   = skip_ack_q;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Scoreboard bench: two sequencers (skip-first and data-first) driven in
// lockstep and compared each cycle against a transaction-level model.
module tb_mem_addr_sequencer;

  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          valid;
    logic [1:0]    src;
    logic          dack;
    logic          sack;
    logic          pend;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n, pc_active, data_req, skip_req, mem_ready;
  logic [AW-1:0] inst_addr, data_addr, skip_addr;

  logic [AW-1:0] address      [2];
  logic          addr_valid   [2];
  logic [1:0]    addr_src     [2];
  logic          data_ack     [2];
  logic          skip_ack     [2];
  logic          skip_pending [2];

  int vectors     = 0;
  int miscompares = 0;

  obs_t exp_q_p1[$];
  obs_t exp_q_p0[$];

  // Model: current transaction (0 none, 1 fetch, 2 data, 3 skip) plus a skip waiting to launch.
  int            m_src  [2];
  logic [AW-1:0] m_addr [2];
  bit            m_wait [2];
  logic [AW-1:0] m_tgt  [2];
  bit            m_dack [2];
  bit            m_sack [2];

  always #5 clk = ~clk;

  mem_addr_sequencer #(.ADDR_W(AW), .SKIP_PRIO(1'b1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .pc_active(pc_active), .inst_addr(inst_addr),
    .data_req(data_req), .data_addr(data_addr), .skip_req(skip_req),
    .skip_addr(skip_addr), .mem_ready(mem_ready), .address(address[0]),
    .addr_valid(addr_valid[0]), .addr_src(addr_src[0]), .data_ack(data_ack[0]),
    .skip_ack(skip_ack[0]), .skip_pending(skip_pending[0])
  );

  mem_addr_sequencer #(.ADDR_W(AW), .SKIP_PRIO(1'b0)) u_dut_p0 (
    .clk(clk), .rst_n(rst_n), .pc_active(pc_active), .inst_addr(inst_addr),
    .data_req(data_req), .data_addr(data_addr), .skip_req(skip_req),
    .skip_addr(skip_addr), .mem_ready(mem_ready), .address(address[1]),
    .addr_valid(addr_valid[1]), .addr_src(addr_src[1]), .data_ack(data_ack[1]),
    .skip_ack(skip_ack[1]), .skip_pending(skip_pending[1])
  );

  function automatic obs_t modelObs(input int k);
    obs_t o;
    o.addr  = m_addr[k];
    o.valid = (m_src[k] != 0);
    o.src   = 2'(m_src[k]);
    o.dack  = m_dack[k];
    o.sack  = m_sack[k];
    o.pend  = m_wait[k] || (m_src[k] == 3);
    return o;
  endfunction

  task automatic modelStep(input int k, input bit skip_first);
    bit            eff_wait;
    logic [AW-1:0] eff_tgt;
    int            pick;
    if (!rst_n) begin
      m_src[k] = 0; m_addr[k] = '0; m_wait[k] = 0; m_tgt[k] = '0;
      m_dack[k] = 0; m_sack[k] = 0;
      return;
    end
    eff_wait  = m_wait[k] || skip_req;
    eff_tgt   = skip_req ? skip_addr : m_tgt[k];
    m_dack[k] = 0;
    m_sack[k] = 0;
    if (pc_active) begin
      if (m_src[k] != 0 && mem_ready) begin
        m_dack[k] = (m_src[k] == 2);
        m_sack[k] = (m_src[k] == 3);
      end
      if (m_src[k] == 0 || mem_ready) begin
        if (eff_wait && (skip_first || !data_req)) pick = 3;
        else if (data_req)                         pick = 2;
        else                                       pick = 1;
        m_src[k]  = pick;
        m_addr[k] = (pick == 3) ? eff_tgt : (pick == 2) ? data_addr : inst_addr;
        if (pick == 3) eff_wait = 0;
      end
    end
    m_wait[k] = eff_wait;
    m_tgt[k]  = eff_tgt;
  endtask

  task automatic checkOutput(input string name, input int k, input obs_t exp);
    obs_t act;
    act = {address[k], addr_valid[k], addr_src[k], data_ack[k], skip_ack[k], skip_pending[k]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d t=%0t: got addr=%h valid=%b src=%b dack=%b sack=%b pend=%b, expected addr=%h valid=%b src=%b dack=%b sack=%b pend=%b",
               name, k, $time, act.addr, act.valid, act.src, act.dack, act.sack, act.pend,
               exp.addr, exp.valid, exp.src, exp.dack, exp.sack, exp.pend);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit pc, input logic [AW-1:0] ia,
                               input bit dr, input logic [AW-1:0] da, input bit sr,
                               input logic [AW-1:0] sa, input bit mr);
    @(negedge clk);
    rst_n = r; pc_active = pc; inst_addr = ia; data_req = dr; data_addr = da;
    skip_req = sr; skip_addr = sa; mem_ready = mr;
    modelStep(0, 1'b1);
    modelStep(1, 1'b0);
    exp_q_p1.push_back(modelObs(0));
    exp_q_p0.push_back(modelObs(1));
    if (!r) begin
      #1;
      checkOutput("async_reset", 0, '0);
      checkOutput("async_reset", 1, '0);
    end
  endtask

  // Monitor: one expectation per DUT per clock edge, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_p1.size() > 0) checkOutput("cycle", 0, exp_q_p1.pop_front());
      if (exp_q_p0.size() > 0) checkOutput("cycle", 1, exp_q_p0.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; pc_active = 1'b0; inst_addr = '0; data_req = 1'b0; data_addr = '0;
    skip_req = 1'b0; skip_addr = '0; mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_src[k] = 0; m_addr[k] = '0; m_wait[k] = 0; m_tgt[k] = '0; m_dack[k] = 0; m_sack[k] = 0;
    end

    applyStimulus(0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0);
    applyStimulus(0, 0, 5'h00, 0, 5'h00, 0, 5'h00, 0);
    // first fetch from IDLE
    applyStimulus(1, 1, 5'h03, 0, 5'h00, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h03, 0, 5'h00, 0, 5'h00, 1);
    // data access, then stall with a skip pulse arriving mid-DATA
    applyStimulus(1, 1, 5'h03, 1, 5'h1A, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h04, 0, 5'h1A, 0, 5'h00, 0);
    applyStimulus(1, 1, 5'h04, 0, 5'h1A, 1, 5'h10, 0);
    applyStimulus(1, 1, 5'h04, 0, 5'h1A, 0, 5'h00, 0);
    applyStimulus(1, 1, 5'h04, 0, 5'h1A, 0, 5'h00, 0);
    applyStimulus(1, 1, 5'h04, 0, 5'h1A, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h04, 0, 5'h1A, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h05, 0, 5'h00, 0, 5'h00, 0);
    // two skip pulses while stalled: last target wins, one ack
    applyStimulus(1, 1, 5'h05, 0, 5'h00, 1, 5'h08, 0);
    applyStimulus(1, 1, 5'h05, 0, 5'h00, 0, 5'h00, 0);
    applyStimulus(1, 1, 5'h05, 0, 5'h00, 1, 5'h0C, 0);
    applyStimulus(1, 1, 5'h05, 0, 5'h00, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h06, 0, 5'h00, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h07, 0, 5'h00, 0, 5'h00, 1);
    // pending skip against data request: the two instances diverge
    applyStimulus(1, 1, 5'h07, 0, 5'h00, 1, 5'h15, 0);
    applyStimulus(1, 1, 5'h07, 1, 5'h12, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h07, 0, 5'h12, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h08, 0, 5'h00, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h09, 0, 5'h00, 0, 5'h00, 0);
    // freeze mid-FETCH with a skip pulse, then resume
    applyStimulus(1, 0, 5'h0A, 1, 5'h0B, 1, 5'h1E, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 5'h0A, 1, 5'h0B, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h0A, 0, 5'h00, 0, 5'h00, 1);
    applyStimulus(1, 1, 5'h0A, 0, 5'h00, 0, 5'h00, 0);
    // reset asserted mid-SKIP
    applyStimulus(0, 1, 5'h0A, 0, 5'h00, 0, 5'h00, 0);
    applyStimulus(1, 1, 5'h0A, 0, 5'h00, 0, 5'h00, 1);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 9) != 0),
                    AW'($urandom_range(0, 31)),
                    ($urandom_range(0, 9) < 3),
                    AW'($urandom_range(0, 31)),
                    ($urandom_range(0, 19) < 3),
                    AW'($urandom_range(0, 31)),
                    ($urandom_range(0, 9) < 6));
    end

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q_p1.size() != 0 || exp_q_p0.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d/%0d left, expected 0/0",
               exp_q_p1.size(), exp_q_p0.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
